// File: rtl/fetch_unit.sv
// Dual-issue fetch front end: PC, two-wide ROM addressing, 2-entry pair queue
// toward decode, and redirect flushing.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [9:0]  rom_addr,
    input  logic [31:0] rom_instr1,
    input  logic [31:0] rom_instr2,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic        id_valid2,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr1,
    output logic [31:0] id_instr2
);

    logic [31:0] pc_q;
    logic        inflight;
    logic [31:0] inflight_pc;
    logic [1:0]  count;
    logic        rd_ptr;
    logic        wr_ptr;

    logic [31:0] q_instr1 [2];
    logic [31:0] q_instr2 [2];
    logic [31:0] q_pc     [2];
    logic        q_valid2 [2];

    logic        pop;
    logic [2:0]  occupancy;
    logic        do_issue;
    logic        do_push;
    logic        slot2_ok;
    logic        unused_bits;

    assign unused_bits = ^redirect_pc[1:0];
    assign rom_addr    = pc_q[11:2];

    assign pop       = id_valid & id_ready;
    // Pairs already owned (queued or in the ROM) once this cycle's pop is taken out.
    assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    assign do_issue  = ~rst & ~redirect_valid & (occupancy < 3'd2);
    assign do_push   = ~rst & ~redirect_valid & inflight;
    assign slot2_ok  = (inflight_pc[11:2] != 10'h3FF);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            inflight <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else if (redirect_valid) begin
            pc_q     <= {redirect_pc[31:2], 2'b00};
            inflight <= 1'b0;
            count    <= 2'd0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            inflight <= do_issue;
            if (do_issue)
                pc_q <= pc_q + 32'd8;
            if (inflight)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end

    // Data storage carries no reset; validity is tracked by count/inflight.
    always_ff @(posedge clk) begin
        if (do_issue)
            inflight_pc <= pc_q;
        if (do_push) begin
            q_instr1[wr_ptr] <= rom_instr1;
            q_instr2[wr_ptr] <= slot2_ok ? rom_instr2 : NOP;
            q_pc[wr_ptr]     <= inflight_pc;
            q_valid2[wr_ptr] <= slot2_ok;
        end
    end

    assign id_valid  = (count != 2'd0);
    assign id_valid2 = id_valid ? q_valid2[rd_ptr] : 1'b0;
    assign id_pc     = id_valid ? q_pc[rd_ptr]     : 32'd0;
    assign id_instr1 = id_valid ? q_instr1[rd_ptr] : NOP;
    assign id_instr2 = id_valid ? q_instr2[rd_ptr] : NOP;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed per-cycle vector table, then random traffic
// against a pc-stream reference model.
module tb_fetch_unit;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam logic [31:0] NOPV  = 32'h0000_0013;
    localparam int          NVEC  = 17;
    localparam int          NRAND = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  rom_addr;
    logic [31:0] rom_instr1;
    logic [31:0] rom_instr2;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic        id_valid2;
    logic [31:0] id_pc;
    logic [31:0] id_instr1;
    logic [31:0] id_instr2;

    int errors = 0;
    int checks = 0;

    fetch_unit #(.RESET_PC(32'h0000_0000), .NOP(NOPV)) dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr),
        .rom_instr1(rom_instr1), .rom_instr2(rom_instr2),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .id_valid(id_valid), .id_valid2(id_valid2),
        .id_pc(id_pc), .id_instr1(id_instr1), .id_instr2(id_instr2)
    );

    always #5 clk = ~clk;

    // Registered two-wide ROM: rom[i] = BASE + i, 1024 words.
    always @(posedge clk) begin
        rom_instr1 <= BASE + {22'd0, rom_addr};
        rom_instr2 <= BASE + {22'd0, rom_addr + 10'd1};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        v;
        logic        v2;
        logic [31:0] pc;
        logic [31:0] i1;
        logic [31:0] i2;
        logic [9:0]  ra;
    } vec_t;

    vec_t tbl [NVEC];

    // Reference: the pc each delivered pair must carry, plus edges since the last flush.
    logic [31:0] exp_pc;
    int          since;
    logic        hold;
    logic        h_v2;
    logic [31:0] h_pc, h_i1, h_i2;
    logic [31:0] tgt;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0,    NOPV,          NOPV,      10'd0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0,    NOPV,          NOPV,      10'd2};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h0,    BASE + 0,      BASE + 1,  10'd4};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h8,    BASE + 2,      BASE + 3,  10'd6};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h10,   BASE + 4,      BASE + 5,  10'd8};
        tbl[5]  = '{1'b0, 1'b1, 32'h42,  1'b1, 1'b0, 1'b0, 32'h0,    NOPV,          NOPV,      10'd16};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0,    NOPV,          NOPV,      10'd18};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h40,   BASE + 16,     BASE + 17, 10'd20};
        tbl[8]  = '{1'b0, 1'b1, 32'hFFC, 1'b1, 1'b0, 1'b0, 32'h0,    NOPV,          NOPV,      10'd1023};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0,    NOPV,          NOPV,      10'd1};
        tbl[10] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b0, 32'hFFC,  BASE + 32'h3FF, NOPV,     10'd3};
        tbl[11] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h1004, BASE + 1,      BASE + 2,  10'd5};
        tbl[12] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h1004, BASE + 1,      BASE + 2,  10'd5};
        tbl[13] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h1004, BASE + 1,      BASE + 2,  10'd5};
        tbl[14] = '{1'b1, 1'b1, 32'h80,  1'b0, 1'b0, 1'b0, 32'h0,    NOPV,          NOPV,      10'd0};
        tbl[15] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h0,    NOPV,          NOPV,      10'd2};
        tbl[16] = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b1, 1'b1, 32'h0,    BASE + 0,      BASE + 1,  10'd4};

        @(posedge clk);
        #1;
        for (int k = 0; k < NVEC; k++) begin
            rst            = tbl[k].rst;
            redirect_valid = tbl[k].rv;
            redirect_pc    = tbl[k].rpc;
            id_ready       = tbl[k].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d id_valid", k),  {31'd0, id_valid},  {31'd0, tbl[k].v});
            chk($sformatf("vec%0d id_valid2", k), {31'd0, id_valid2}, {31'd0, tbl[k].v2});
            chk($sformatf("vec%0d id_pc", k),     id_pc,              tbl[k].pc);
            chk($sformatf("vec%0d id_instr1", k), id_instr1,          tbl[k].i1);
            chk($sformatf("vec%0d id_instr2", k), id_instr2,          tbl[k].i2);
            chk($sformatf("vec%0d rom_addr", k),  {22'd0, rom_addr},  {22'd0, tbl[k].ra});
        end

        // Head pair pc 0 is showing, two edges after the reset in vector 14.
        exp_pc = 32'd0;
        since  = 2;
        hold   = 1'b0;
        for (int c = 0; c < NRAND; c++) begin
            rst            = ($urandom_range(0, 199) == 0);
            redirect_valid = ($urandom_range(0, 99) < 4);
            case ($urandom_range(0, 2))
                0:       tgt = $urandom;
                1:       tgt = 32'h0000_0FF0 + 32'($urandom_range(0, 15));
                default: tgt = ($urandom & 32'hFFFF_F000) | 32'h0000_0FF8;
            endcase
            redirect_pc = tgt;
            id_ready    = ($urandom_range(0, 99) < 70);

            chk("rand id_valid", {31'd0, id_valid}, {31'd0, (since >= 2)});
            if (hold) begin
                chk("hold id_pc",     id_pc,     h_pc);
                chk("hold id_instr1", id_instr1, h_i1);
                chk("hold id_instr2", id_instr2, h_i2);
                chk("hold id_valid2", {31'd0, id_valid2}, {31'd0, h_v2});
            end
            if (!id_valid) begin
                chk("idle id_pc",     id_pc,     32'd0);
                chk("idle id_instr1", id_instr1, NOPV);
                chk("idle id_instr2", id_instr2, NOPV);
                chk("idle id_valid2", {31'd0, id_valid2}, 32'd0);
            end else if (id_ready) begin
                chk("pair id_pc",     id_pc,     exp_pc);
                chk("pair id_instr1", id_instr1, BASE + {22'd0, exp_pc[11:2]});
                if (exp_pc[11:2] == 10'h3FF) begin
                    chk("wrap id_valid2", {31'd0, id_valid2}, 32'd0);
                    chk("wrap id_instr2", id_instr2, NOPV);
                end else begin
                    chk("pair id_valid2", {31'd0, id_valid2}, 32'd1);
                    chk("pair id_instr2", id_instr2, BASE + {22'd0, exp_pc[11:2] + 10'd1});
                end
            end

            hold = id_valid & ~id_ready & ~rst & ~redirect_valid;
            h_pc = id_pc;  h_i1 = id_instr1;  h_i2 = id_instr2;  h_v2 = id_valid2;
            if (rst) begin
                exp_pc = 32'd0;
                since  = 0;
            end else if (redirect_valid) begin
                exp_pc = {tgt[31:2], 2'b00};
                since  = 0;
            end else begin
                if (id_valid && id_ready)
                    exp_pc = exp_pc + 32'd8;
                since++;
            end
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
